// File: rtl/sync_fifo_flex_pkg.sv
// Shared types, default thresholds and sizing helpers for sync_fifo_flex.
package sync_fifo_flex_pkg;

  // Read-side presentation mode.
  typedef enum logic {
    RD_REG  = 1'b0,  // popped word appears one cycle after the accepted read
    RD_FWFT = 1'b1   // head word is always presented while not empty
  } rd_mode_e;

  // Default almost-empty threshold (count <= this asserts o_almost_empty).
  localparam int DEF_AE_THRESH = 2;

  // Default almost-full margin: o_almost_full asserts at DEPTH - this.
  localparam int DEF_AF_MARGIN = 2;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Bus bundle between a producer/consumer and sync_fifo_flex.
//
// Handshake: a write is taken on a rising edge where i_wren is high and the
// FIFO has room, or is full but also takes a read in that same cycle. A read
// is taken on a rising edge where i_rden is high and the FIFO holds at least
// one word. Requests that are not taken are dropped (never retried) and set
// the sticky o_overflow / o_underflow flags until i_clr_err clears them.
interface sync_fifo_flex_if
  import sync_fifo_flex_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);

  localparam int CNT_W = clog2_cnt(DEPTH);

  logic [DATA_W-1:0] i_data;
  logic              i_wren;
  logic              i_rden;
  logic              i_clr_err;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_full;
  logic              o_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;
  logic              o_underflow;

  // Producer/consumer side.
  modport master (
    output i_data, i_wren, i_rden, i_clr_err,
    input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  // FIFO side.
  modport slave (
    input  i_data, i_wren, i_rden, i_clr_err,
    output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

endinterface

// File: rtl/sync_fifo_flex_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// A read of the address being written in the same cycle returns the old word.
module sync_fifo_flex_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [PTR_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [PTR_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the count decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, programmable almost flags, sticky
// error flags, write-on-full with concurrent read, and a selectable
// registered or first-word-fall-through read side.
module sync_fifo_flex
  import sync_fifo_flex_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH,
  parameter int FWFT      = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sync_fifo_flex_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = clog2_cnt(DEPTH);

  localparam rd_mode_e         RD_MODE  = (FWFT != 0) ? RD_FWFT : RD_REG;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_ok;
  logic              wr_ok;
  logic [DATA_W-1:0] ram_rd_data;

  // Accept decisions use the pre-edge count; a full FIFO still takes a write
  // when a read frees a slot in the same cycle.
  always_comb begin
    rd_ok = bus.i_rden && (count_q != '0);
    wr_ok = bus.i_wren && ((count_q != FULL_CNT) || rd_ok);
  end

  // Next pointers, count, flags and sticky errors.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_CNT);
    ae_d    = (count_d <= AE_CNT);

    // A fresh error wins over a clear arriving in the same cycle.
    if (bus.i_wren && !wr_ok) begin
      ovf_d = 1'b1;
    end else if (bus.i_clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (bus.i_rden && !rd_ok) begin
      unf_d = 1'b1;
    end else if (bus.i_clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state register; reset drops all stored words at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  sync_fifo_flex_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (wr_ok),
    .i_wr_addr (wptr_q),
    .i_wr_data (bus.i_data),
    .i_rd_addr (rptr_q),
    .o_rd_data (ram_rd_data)
  );

  assign bus.o_count        = count_q;
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_full  = af_q;
  assign bus.o_almost_empty = ae_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;

  if (RD_MODE == RD_REG) begin : g_rd_reg
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Capture the head word on each accepted read; valid pulses for one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) begin
          data_q <= ram_rd_data;
        end
      end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
  end else begin : g_rd_fwft
    // Head word is shown directly; zero while empty so reset reads as 0.
    assign bus.o_data  = empty_q ? '0 : ram_rd_data;
    assign bus.o_valid = !empty_q;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised successor to the dual-clock FIFO_top.
- Generalises data width and depth, and adds:
  - a fill count;
  - programmable almost-full / almost-empty flags;
  - a selectable first-word-fall-through (FWFT) read mode;
  - sticky overflow / underflow error flags;
  - write-on-full when a read is accepted in the same cycle.
- Used where producer and consumer share a clock, so no Gray-code crossing is needed.

Parameters:
- DATA_W, 8, data word width in bits, >=1.
- DEPTH, 16, number of entries; power of two, >=4.
- AF_THRESH, DEPTH-2, o_almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, o_almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented on o_data while not empty.

Ports:
- i_clk  in  1  single clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  DATA_W  write data.
- i_wren  in  1  write request.
- i_rden  in  1  read request (pop).
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_data  out  DATA_W  read data.
- o_valid  out  1  o_data holds a popped word (mode 0) or a valid head word (mode 1).
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AF_THRESH.
- o_almost_empty  out  1  count <= AE_THRESH.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky; a write was rejected.
- o_underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - pointers and count reset to 0;
  - o_empty=1, o_almost_empty=1;
  - o_full=0, o_almost_full=0 (AF_THRESH>0 required);
  - o_overflow=0, o_underflow=0, o_valid=0, o_data=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored words immediately; first write after deassertion lands at entry 0.
- Pointers: wptr and rptr are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register is authoritative for full and empty.
- Accept rules (evaluated on the pre-edge count):
  - rd_ok = i_rden && count != 0.
  - wr_ok = i_wren && (count != DEPTH || rd_ok). Writing when full is allowed if a read is accepted in the same cycle.
- Count update:
  - wr_ok only: count+1.
  - rd_ok only: count-1.
  - both: count unchanged; both pointers advance.
- Simultaneous read and write at empty: write accepted, read rejected (underflow sets); count becomes 1.
- Errors:
  - i_wren && !wr_ok sets o_overflow.
  - i_rden && !rd_ok sets o_underflow.
  - i_clr_err clears both flags next edge; a new error in the same cycle takes priority over the clear.
- Flags (o_full, o_empty, o_almost_*) are registered and derived from the next count, so they are correct in the cycle after the edge that changes count. No combinational path from i_wren / i_rden to flags.
- FWFT=0:
  - On rd_ok, o_data <= mem[rptr] and o_valid <= 1 at the same edge; data is visible 1 cycle after the accepted read.
  - o_valid is 0 in any cycle following no rd_ok.
  - o_data holds its last value otherwise.
- FWFT=1:
  - o_data = mem[rptr], o_valid = !o_empty.
  - A write into an empty FIFO appears on o_data in the next cycle (1-cycle write-to-read latency).
  - rd_ok consumes the presented word.
- Same-address write and read (the full-case simultaneous access) returns the old word; read-before-write.

Decomposition:
- Package pkg_fifo:
  - function clog2_cnt(DEPTH) returning the count width;
  - typedef enum for read mode {RD_REG, RD_FWFT};
  - localparam default thresholds.
  - pkg_graybin is not needed.
- Sub-module fifo_ram: simple dual-port memory (DATA_W x DEPTH) with synchronous write and asynchronous read. sync_fifo_flex adds the output register for FWFT=0.
- Control logic (pointers, count, flags, errors) lives in sync_fifo_flex.

Test Plan (DEPTH=16, DATA_W=8, AF_THRESH=14, AE_THRESH=2 unless stated):
- Reset, then FWFT=0: write 0x11, 0x22, 0x33; read 3 -> o_data 0x11, 0x22, 0x33, each 1 cycle after its i_rden; o_valid pulses. o_empty is 1 after the last read and o_underflow stays 0.
- Fill with 16 writes 0..15 -> o_almost_full at count 14; o_full at 16. A 17th write -> o_overflow=1 and count stays 16; readout is 0..15 in order.
- At full, assert i_wren (0xAA) and i_rden together -> count stays 16, o_overflow unchanged; after draining, 0xAA is the last word.
- Read when empty -> o_underflow=1, count 0. Pulse i_clr_err -> o_underflow=0 next cycle. Error and clear in the same cycle -> flag stays 1.
- FWFT=1: write 0x5C into empty -> o_data=0x5C, o_valid=1 on the next cycle; assert i_rden -> o_valid=0, o_empty=1.
- Write 20 words, reading 8 in between so pointers wrap, with i_rst_n pulsed low asynchronously mid-burst -> all outputs at reset values immediately. Post-reset write 0x01 then read -> 0x01.
